// File: rtl/serial_add_pkg.sv
// -----------------------------------------------------------------------------
// serial_add_pkg
// Shared types and constants for the bit-serial adder sequencer.
//   state_e        : controller state encoding (IDLE / RUN / DONE)
//   DEFAULT_WIDTH  : default operand/result width in bits
// -----------------------------------------------------------------------------
package serial_add_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage : serial_add_pkg

// File: rtl/serial_adder_ctrl_if.sv
// -----------------------------------------------------------------------------
// serial_adder_ctrl_if
// Start/done handshake bundle between a requester and serial_adder_ctrl.
//   start        : request pulse, only sampled while the adder is idle
//   a, b, cin    : operands, captured on the accepted start edge
//   sub          : (SERIAL_ADD_SUB_EN only) subtract request, captured with start
//   busy         : high while an operation is in RUN or DONE
//   done         : one-cycle pulse, sum/cout valid
//   sum, cout    : result, held until the next operation completes
// Handshake: a start is accepted on the rising edge where start=1 and busy=0;
// start while busy=1 is dropped, never queued. Exactly one done pulse follows
// every accepted start unless reset intervenes.
// Modports: master = requester side, slave = adder side.
// Optional feature macro: SERIAL_ADD_SUB_EN.
// -----------------------------------------------------------------------------
interface serial_adder_ctrl_if #(
   parameter int WIDTH = serial_add_pkg::DEFAULT_WIDTH
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
`ifdef SERIAL_ADD_SUB_EN
   logic             sub;
`endif
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;

   modport master (
      output start, a, b, cin,
`ifdef SERIAL_ADD_SUB_EN
      output sub,
`endif
      input  busy, done, sum, cout
   );

   modport slave (
      input  start, a, b, cin,
`ifdef SERIAL_ADD_SUB_EN
      input  sub,
`endif
      output busy, done, sum, cout
   );

endinterface : serial_adder_ctrl_if

// File: rtl/fullAdder.sv
// -----------------------------------------------------------------------------
// fullAdder
// Single-bit full-adder cell.
//   a_i, b_i, cin_i : addend bits and carry-in
//   sum_o, cout_o   : sum bit and carry-out
// -----------------------------------------------------------------------------
module fullAdder (
   input  logic a_i,
   input  logic b_i,
   input  logic cin_i,
   output logic sum_o,
   output logic cout_o
);

   logic half_s;

   assign half_s = a_i ^ b_i;
   assign sum_o  = half_s ^ cin_i;
   assign cout_o = (a_i & b_i) | (cin_i & half_s);

endmodule : fullAdder

// File: rtl/serial_adder_ctrl.sv
// -----------------------------------------------------------------------------
// serial_adder_ctrl
// Bit-serial adder: one fullAdder cell is time-shared over WIDTH clocks,
// LSB first, giving {cout,sum} = a + b + cin (mod 2^(WIDTH+1)).
// Ports:
//   clk     : rising-edge clock
//   rst_n   : synchronous active-low reset; aborts any operation, no done
//   bus     : serial_adder_ctrl_if.slave (start/a/b/cin[/sub] in,
//             busy/done/sum/cout out)
//   state_o : current controller state, for observation
// Timing: start accepted at edge 0, WIDTH RUN edges, done high during the
// cycle after edge WIDTH, back in IDLE one cycle later (WIDTH+2 per op).
// Optional feature macro: SERIAL_ADD_SUB_EN adds bus.sub; when set, b is
// inverted at capture and the carry starts at 1, giving a - b (cout=1 means
// no borrow).
// -----------------------------------------------------------------------------
module serial_adder_ctrl
   import serial_add_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic                clk,
   input  logic                rst_n,
   serial_adder_ctrl_if.slave  bus,
   output state_e              state_o
);

   localparam int               CNT_W    = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   a_sh_q;
   logic [WIDTH-1:0]   b_sh_q;
   logic [WIDTH-1:0]   sum_sh_q;
   logic [WIDTH-1:0]   sum_sh_d;
   logic               carry_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [WIDTH-1:0]   sum_q;
   logic               cout_q;

   logic               fa_sum;
   logic               fa_cout;
   logic [WIDTH-1:0]   b_cap;
   logic               carry_cap;
   logic               last_bit;

   // Operand conditioning at capture time; subtraction is a + ~b + 1.
`ifdef SERIAL_ADD_SUB_EN
   assign b_cap     = bus.sub ? ~bus.b : bus.b;
   assign carry_cap = bus.sub | bus.cin;
`else
   assign b_cap     = bus.b;
   assign carry_cap = bus.cin;
`endif

   fullAdder u_fa (
      .a_i    (a_sh_q[0]),
      .b_i    (b_sh_q[0]),
      .cin_i  (carry_q),
      .sum_o  (fa_sum),
      .cout_o (fa_cout)
   );

   // New sum bit enters at the MSB so that after WIDTH shifts the first
   // (LSB) result bit has travelled down to position 0.
   assign sum_sh_d = {fa_sum, sum_sh_q[WIDTH-1:1]};
   assign last_bit = (cnt_q == CNT_LAST);

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.start) state_d = RUN;
         RUN:     if (last_bit)  state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      bus.busy = (state_q == RUN) || (state_q == DONE);
      bus.done = (state_q == DONE);
      bus.sum  = sum_q;
      bus.cout = cout_q;
      state_o  = state_q;
   end

   // ---------------- Datapath: shifters, carry, counter, result ----------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         a_sh_q   <= '0;
         b_sh_q   <= '0;
         sum_sh_q <= '0;
         carry_q  <= 1'b0;
         cnt_q    <= '0;
         sum_q    <= '0;
         cout_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.start) begin
                  a_sh_q   <= bus.a;
                  b_sh_q   <= b_cap;
                  carry_q  <= carry_cap;
                  cnt_q    <= '0;
                  sum_sh_q <= '0;
               end
            end
            RUN: begin
               a_sh_q   <= a_sh_q >> 1;
               b_sh_q   <= b_sh_q >> 1;
               sum_sh_q <= sum_sh_d;
               carry_q  <= fa_cout;
               cnt_q    <= cnt_q + CNT_W'(1);
               // Result registers only change on the final bit, so the
               // previous result stays visible throughout a new operation.
               if (last_bit) begin
                  sum_q  <= sum_sh_d;
                  cout_q <= fa_cout;
               end
            end
            default: ;
         endcase
      end
   end

endmodule : serial_adder_ctrl
